// File: rtl/zbuf_pkg.sv
// Shared types for the Z-buffer scan reader: scan FSM states, the far-plane
// depth constant and the pixel record carried through the output FIFO.
package zbuf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } scan_state_t;

  // Depth is carried at the widest supported width and trimmed at the ports.
  localparam int Z_MAX_BITS = 16;
  localparam logic [Z_MAX_BITS-1:0] Z_FAR = '1;

  typedef struct packed {
    logic [7:0]            x;
    logic [6:0]            y;
    logic [Z_MAX_BITS-1:0] z;
    logic                  last;
  } pixel_t;

endpackage

// File: rtl/zbuf_scan_reader_if.sv
// Bus bundle for the scan reader: shared-port depth RAM plus the
// valid/ready pixel output stream.
interface zbuf_scan_reader_if #(
  parameter int ADDR_BITS = 15,
  parameter int Z_BITS    = 8
);

  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_re;
  logic                 mem_we;
  logic [Z_BITS-1:0]    mem_wdata;
  logic [Z_BITS-1:0]    mem_rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_x;
  logic [6:0]           out_y;
  logic [Z_BITS-1:0]    out_z;
  logic                 out_last;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata,
    output out_valid, out_x, out_y, out_z, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata,
    input  out_valid, out_x, out_y, out_z, out_last,
    output out_ready
  );

endinterface

// File: rtl/zbuf_out_fifo.sv
// Two-entry registered pixel FIFO with valid/ready pop side and a
// synchronous flush; the head entry drives the outputs directly.
module zbuf_out_fifo
  import zbuf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  pixel_t     push_data,
  input  logic       pop_ready,
  output logic       pop_valid,
  output pixel_t     pop_data,
  output logic [1:0] count
);

  pixel_t     head_q, head_d;
  pixel_t     tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       pop;

  assign pop = pop_valid & pop_ready;

  // The head only moves on a pop or when empty, so a stalled output stays put.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = push_data;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (pop && push) begin
            head_d = push_data;
          end else if (pop) begin
            count_d = 2'd0;
          end else if (push) begin
            tail_d  = push_data;
            count_d = 2'd2;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d = tail_q;
            if (push) tail_d = push_data;
            else      count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign pop_valid = (count_q != 2'd0);
  assign pop_data  = head_q;
  assign count     = count_q;

endmodule

// File: rtl/zbuf_scan_reader.sv
// Z-buffer read side: scans one frame forward or backward, reads depth from a
// 1-cycle sync RAM, optionally clears behind the scan, and streams (x,y,z).
module zbuf_scan_reader
  import zbuf_pkg::*;
#(
  parameter int H_RES     = 160,
  parameter int V_RES     = 120,
  parameter int Z_BITS    = 8,
  parameter int ADDR_BITS = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic reverse,
  input  logic clear_en,
  input  logic abort,
  output logic busy,
  output logic done,
  zbuf_scan_reader_if.master bus
);

  localparam logic [7:0]           X_MAX  = 8'(H_RES - 1);
  localparam logic [6:0]           Y_MAX  = 7'(V_RES - 1);
  localparam logic [ADDR_BITS-1:0] A_LAST = ADDR_BITS'(H_RES * V_RES - 1);

  scan_state_t          state_q, state_d;
  logic [7:0]           x_q, x_d;
  logic [6:0]           y_q, y_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rev_q, rev_d;
  logic                 clr_q, clr_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]           rd_x_q, rd_x_d;
  logic [6:0]           rd_y_q, rd_y_d;
  logic                 rd_last_q, rd_last_d;

  logic       start_ok, scan_last, issue, fifo_valid, fifo_pop, unused_z;
  logic [1:0] fifo_count;
  logic [2:0] occ;
  pixel_t     push_pix, head_pix;

  assign start_ok  = (state_q == IDLE) && start && !abort;
  assign scan_last = rev_q ? (addr_q == '0) : (addr_q == A_LAST);
  assign fifo_pop  = fifo_valid & bus.out_ready;

  // Occupancy counts a pop happening this cycle so plain mode sustains 1 pixel/cycle.
  assign occ   = 3'(fifo_count) + 3'(rd_pend_q) - 3'(fifo_pop);
  assign issue = (state_q == RUN) && !abort && !(rd_pend_q && clr_q) && (occ < 3'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (abort) state_d = IDLE;
               else if (issue && scan_last) state_d = DRAIN;
      DRAIN:   if (abort) state_d = IDLE;
               else if (fifo_pop && head_pix.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_re    = issue;
    bus.mem_we    = rd_pend_q && clr_q && !abort;
    bus.mem_addr  = bus.mem_we ? rd_addr_q : addr_q;
    bus.mem_wdata = Z_FAR[Z_BITS-1:0];
    busy          = (state_q != IDLE);
    done          = (state_q == DRAIN) && fifo_pop && head_pix.last && !abort;
  end

  // The linear address tracks x/y so the RAM address needs no multiplier.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    rev_d     = rev_q;
    clr_d     = clr_q;
    rd_pend_d = issue;
    rd_addr_d = rd_addr_q;
    rd_x_d    = rd_x_q;
    rd_y_d    = rd_y_q;
    rd_last_d = rd_last_q;
    if (start_ok) begin
      rev_d  = reverse;
      clr_d  = clear_en;
      x_d    = reverse ? X_MAX : 8'd0;
      y_d    = reverse ? Y_MAX : 7'd0;
      addr_d = reverse ? A_LAST : '0;
    end else if (issue) begin
      rd_addr_d = addr_q;
      rd_x_d    = x_q;
      rd_y_d    = y_q;
      rd_last_d = scan_last;
      if (rev_q) begin
        if (x_q == 8'd0) begin
          x_d = X_MAX;
          y_d = y_q - 7'd1;
        end else begin
          x_d = x_q - 8'd1;
        end
        addr_d = addr_q - ADDR_BITS'(1);
      end else begin
        if (x_q == X_MAX) begin
          x_d = 8'd0;
          y_d = y_q + 7'd1;
        end else begin
          x_d = x_q + 8'd1;
        end
        addr_d = addr_q + ADDR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      rev_q     <= 1'b0;
      clr_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      rd_last_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      rev_q     <= rev_d;
      clr_q     <= clr_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
      rd_last_q <= rd_last_d;
    end
  end

  always_comb begin
    push_pix.x    = rd_x_q;
    push_pix.y    = rd_y_q;
    push_pix.z    = Z_MAX_BITS'(bus.mem_rdata);
    push_pix.last = rd_last_q;
  end

  zbuf_out_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .push      (rd_pend_q),
    .push_data (push_pix),
    .pop_ready (bus.out_ready),
    .pop_valid (fifo_valid),
    .pop_data  (head_pix),
    .count     (fifo_count)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_x     = head_pix.x;
  assign bus.out_y     = head_pix.y;
  assign bus.out_z     = head_pix.z[Z_BITS-1:0];
  assign bus.out_last  = head_pix.last;
  assign unused_z      = ^head_pix.z;

endmodule

// File: tb/tb_zbuf_scan_reader.sv
// Scoreboard bench for zbuf_scan_reader on a 4x2 frame: expected pixels are
// queued when a scan starts and a negedge monitor checks every transfer.
module tb_zbuf_scan_reader;

   localparam int H    = 4;
   localparam int V    = 2;
   localparam int ZB   = 8;
   localparam int AB   = 3;
   localparam int NPIX = H * V;

   logic clk, reset, start, reverse, clear_en, abort, busy, done;

   zbuf_scan_reader_if #(.ADDR_BITS(AB), .Z_BITS(ZB)) bus ();

   zbuf_scan_reader #(
      .H_RES(H), .V_RES(V), .Z_BITS(ZB), .ADDR_BITS(AB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .reverse  (reverse),
      .clear_en (clear_en),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .bus      (bus)
   );

   logic [23:0]   sbQ[$];
   logic [7:0]    ram    [NPIX];
   logic [7:0]    expMem [NPIX];
   logic          reloadRam;
   logic          inflightChk;
   logic          prevRe;
   logic [AB-1:0] prevAddr;
   logic [3:0]    readyPat;
   int            passCnt, totalCnt;
   int            popCnt, issCnt, doneCnt, wrCnt;
   int            popBase, issBase, doneBase, wrBase;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void checkOutput(input string name, input logic [31:0] act,
                                       input logic [31:0] req);
      totalCnt++;
      if (act === req) passCnt++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endfunction

   // Behavioural sync RAM: one-cycle read latency, write on the shared address.
   always @(posedge clk) begin
      if (reloadRam) begin
         for (int i = 0; i < NPIX; i++) ram[i] <= 8'(i);
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
   end

   // Monitor: pops the scoreboard on each transfer and checks clear write-backs.
   always @(negedge clk) begin
      logic [23:0] got;
      logic [23:0] want;
      int outstanding;
      if (!reset) begin
         prevRe = 1'b0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            popCnt++;
            got = {bus.out_x, bus.out_y, bus.out_z, bus.out_last};
            if (sbQ.size() == 0) begin
               totalCnt++;
               $display("[TB] FAIL pixel_unexpected: got 0x%0h, required no transfer", got);
            end else begin
               want = sbQ.pop_front();
               checkOutput("pixel", 32'(got), 32'(want));
            end
         end
         if (bus.mem_we) begin
            wrCnt++;
            checkOutput("clear_writeback", {19'd0, bus.mem_re, prevRe, bus.mem_addr, bus.mem_wdata},
                        {19'd0, 1'b0, 1'b1, prevAddr, 8'hFF});
         end
         if (bus.mem_re) issCnt++;
         if (done) doneCnt++;
         outstanding = (issCnt - issBase) - (popCnt - popBase);
         if (inflightChk) checkOutput("in_flight_le_2", 32'(outstanding <= 2), 32'd1);
         prevRe   = bus.mem_re;
         prevAddr = bus.mem_addr;
      end
   end

   // Queues the expected frame and pulses start; call at posedge+2.
   task automatic applyStimulus(input logic rev, input logic clr);
      logic [23:0] e;
      int a;
      for (int k = 0; k < NPIX; k++) begin
         a = rev ? (NPIX - 1 - k) : k;
         e = {8'(a % H), 7'(a / H), expMem[a], (k == NPIX - 1)};
         sbQ.push_back(e);
         if (clr) expMem[a] = 8'hFF;
      end
      popBase  = popCnt;
      issBase  = issCnt;
      doneBase = doneCnt;
      wrBase   = wrCnt;
      start    = 1'b1;
      reverse  = rev;
      clear_en = clr;
      @(posedge clk); #2;
      start    = 1'b0;
      reverse  = 1'b0;
      clear_en = 1'b0;
   endtask

   task automatic waitScanDone(input bit usePat, input int expWrites);
      bit finished;
      int k;
      finished = 1'b0;
      k = 0;
      while (!finished && k < 300) begin
         if (usePat) bus.out_ready = readyPat[k % 4];
         @(posedge clk); #2;
         k++;
         if (doneCnt != doneBase && !busy) finished = 1'b1;
      end
      checkOutput("scan_completes", 32'(finished), 32'd1);
      bus.out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #2; end
      checkOutput("done_pulses", 32'(doneCnt - doneBase), 32'd1);
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
      checkOutput("busy_idle", 32'(busy), 32'd0);
      checkOutput("write_count", 32'(wrCnt - wrBase), 32'(expWrites));
   endtask

   initial begin
      int issHold, doneHold;
      passCnt = 0; totalCnt = 0; popCnt = 0; issCnt = 0; doneCnt = 0; wrCnt = 0;
      popBase = 0; issBase = 0; doneBase = 0; wrBase = 0;
      prevRe = 1'b0; prevAddr = '0; inflightChk = 1'b0; readyPat = 4'b1001;
      reset = 1'b0; start = 1'b0; reverse = 1'b0; clear_en = 1'b0; abort = 1'b0;
      bus.out_ready = 1'b1; reloadRam = 1'b1;
      for (int i = 0; i < NPIX; i++) expMem[i] = 8'(i);
      repeat (2) begin @(posedge clk); #2; end
      checkOutput("reset_ctrl", {26'd0, busy, done, bus.out_valid, bus.mem_re, bus.mem_we, bus.out_last}, 32'd0);
      checkOutput("reset_data", {5'd0, bus.mem_addr, bus.out_x, bus.out_y, bus.out_z}, 32'd0);
      reset = 1'b1; reloadRam = 1'b0;
      @(posedge clk); #2;

      $display("[TB] forward scan");
      applyStimulus(1'b0, 1'b0);
      waitScanDone(1'b0, 0);

      $display("[TB] reverse scan");
      applyStimulus(1'b1, 1'b0);
      waitScanDone(1'b0, 0);

      $display("[TB] clear-on-read scan and rescan");
      applyStimulus(1'b0, 1'b1);
      waitScanDone(1'b0, NPIX);
      applyStimulus(1'b0, 1'b0);
      waitScanDone(1'b0, 0);
      reloadRam = 1'b1;
      @(posedge clk); #2;
      reloadRam = 1'b0;
      for (int i = 0; i < NPIX; i++) expMem[i] = 8'(i);

      $display("[TB] backpressure scan");
      inflightChk = 1'b1;
      applyStimulus(1'b0, 1'b0);
      waitScanDone(1'b1, 0);
      inflightChk = 1'b0;

      $display("[TB] abort on third pixel");
      applyStimulus(1'b0, 1'b0);
      for (int k = 0; k < 100 && (popCnt - popBase) < 2; k++) begin
         @(posedge clk); #2;
      end
      checkOutput("two_pixels_before_abort", 32'(popCnt - popBase), 32'd2);
      abort = 1'b1;
      bus.out_ready = 1'b0;
      #1;
      checkOutput("abort_no_mem_access", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
      @(posedge clk); #2;
      abort = 1'b0;
      issHold  = issCnt;
      doneHold = doneCnt;
      checkOutput("abort_outputs", {29'd0, bus.out_valid, busy, done}, 32'd0);
      repeat (3) begin @(posedge clk); #2; end
      checkOutput("abort_stays_idle", {30'd0, bus.out_valid, busy}, 32'd0);
      checkOutput("abort_no_reads", 32'(issCnt - issHold), 32'd0);
      checkOutput("abort_no_done", 32'(doneCnt - doneHold), 32'd0);
      sbQ.delete();
      bus.out_ready = 1'b1;
      applyStimulus(1'b0, 1'b0);
      waitScanDone(1'b0, 0);

      $display("[TB] start during run ignored");
      applyStimulus(1'b0, 1'b0);
      @(posedge clk); #2;
      start = 1'b1; reverse = 1'b1; clear_en = 1'b1;
      @(posedge clk); #2;
      start = 1'b0; reverse = 1'b0; clear_en = 1'b0;
      waitScanDone(1'b0, 0);

      $display("[TB] reset mid-run");
      applyStimulus(1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #2; end
      reset = 1'b0;
      #1;
      checkOutput("midrun_reset_ctrl", {26'd0, busy, done, bus.out_valid, bus.mem_re, bus.mem_we, bus.out_last}, 32'd0);
      checkOutput("midrun_reset_data", {5'd0, bus.mem_addr, bus.out_x, bus.out_y, bus.out_z}, 32'd0);
      @(posedge clk); #2;
      reset = 1'b1;
      sbQ.delete();
      @(posedge clk); #2;
      applyStimulus(1'b1, 1'b0);
      waitScanDone(1'b0, 0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
